// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// FSM states, ALU operation codes, opcode constants and mux select codes.
package riscv_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
      S_EXECI, S_UIMM, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLT   = 4'd5,
      ALU_SLTU  = 4'd6,
      ALU_SLL   = 4'd7,
      ALU_SRL   = 4'd8,
      ALU_SRA   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_t;

   // How the ALU decoder interprets funct3/funct7b5 in a given state.
   typedef enum logic [2:0] {
      MODE_ADD, MODE_SUB, MODE_R, MODE_I, MODE_PASSB
   } alu_mode_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RS1   = 2'b10;
   localparam logic [1:0] SRC_B_RS2   = 2'b00;
   localparam logic [1:0] SRC_B_IMM   = 2'b01;
   localparam logic [1:0] SRC_B_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_RDATA   = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   function automatic logic [2:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_STORE:          return IMM_S;
         OP_BRANCH:         return IMM_B;
         OP_JAL:            return IMM_J;
         OP_LUI, OP_AUIPC:  return IMM_U;
         default:           return IMM_I;
      endcase
   endfunction

   // funct3 010/011 are not branches; they never take.
   function automatic logic br_taken(input logic [2:0] funct3, input logic zero,
                                     input logic lt, input logic ltu);
      case (funct3)
         3'b000:  return zero;
         3'b001:  return !zero;
         3'b100:  return lt;
         3'b101:  return !lt;
         3'b110:  return ltu;
         3'b111:  return !ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decoder: maps funct3/funct7b5 to an ALU op code, or forces
// ADD/SUB/PASSB when the controlling state needs a fixed operation.
module alu_dec
   import riscv_pkg::*;
#(
   parameter int ALU_CTRL_W = 4
) (
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   input  alu_mode_t             mode,
   output logic [ALU_CTRL_W-1:0] alu_control
);

   alu_op_t aop;

   always_comb begin
      aop = ALU_ADD;
      case (mode)
         MODE_SUB:   aop = ALU_SUB;
         MODE_PASSB: aop = ALU_PASSB;
         MODE_R, MODE_I: begin
            // Immediate forms have no SUB; funct7b5 there is part of the immediate.
            case (funct3)
               3'b000: aop = (mode == MODE_R && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001: aop = ALU_SLL;
               3'b010: aop = ALU_SLT;
               3'b011: aop = ALU_SLTU;
               3'b100: aop = ALU_XOR;
               3'b101: aop = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110: aop = ALU_OR;
               3'b111: aop = ALU_AND;
            endcase
         end
         default:    aop = ALU_ADD;
      endcase
   end

   assign alu_control = ALU_CTRL_W'(aop);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RISC-V control FSM: state-decoded datapath controls, memory
// handshake with optional wait timeout, and sticky illegal/bus-error flags.
module mc_ctrl
   import riscv_pkg::*;
#(
   parameter int ALU_CTRL_W  = 4,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            op,
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   input  logic                  zero,
   input  logic                  lt,
   input  logic                  ltu,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  mem_write,
   output logic                  adr_src,
   output logic                  ir_write,
   output logic                  pc_write,
   output logic                  reg_write,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            result_src,
   output logic [2:0]            imm_src,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  illegal,
   output logic                  bus_err,
   output logic [3:0]            state_o
);

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          timeout;
   alu_mode_t     alu_mode;

   assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);
   assign imm_src = imm_sel(op);
   assign state_o = state;

   alu_dec #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .mode        (alu_mode),
      .alu_control (alu_control)
   );

   always_comb begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      result_src = RES_ALUOUT;
      alu_mode   = MODE_ADD;
      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
         end
         S_MEMADR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = RES_RDATA;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRC_A_RS1;
            alu_mode  = MODE_R;
         end
         S_EXECI: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            alu_mode  = MODE_I;
         end
         S_UIMM: begin
            alu_src_b = SRC_B_IMM;
            if (op == OP_LUI) alu_mode = MODE_PASSB;
            else              alu_src_a = SRC_A_OLDPC;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = SRC_A_RS1;
            alu_mode  = MODE_SUB;
            pc_write  = br_taken(funct3, zero, lt, ltu);
         end
         S_JALR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
         end
         S_JAL: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_FOUR;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
      // Strobes must drop the instant reset asserts, even mid-access.
      if (!rst_n) begin
         mem_req   = 1'b0;
         mem_write = 1'b0;
         adr_src   = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         reg_write = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         illegal  <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         wait_cnt <= '0;
         unique case (state)
            S_FETCH, S_MEMREAD, S_MEMWRITE: begin
               if (mem_ready) begin
                  if (state == S_FETCH)        state <= S_DECODE;
                  else if (state == S_MEMREAD) state <= S_MEMWB;
                  else                         state <= S_FETCH;
               end else if (timeout) begin
                  state   <= S_TRAP;
                  bus_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               case (op)
                  OP_LOAD, OP_STORE: state <= S_MEMADR;
                  OP_R:              state <= S_EXECR;
                  OP_I:              state <= S_EXECI;
                  OP_LUI, OP_AUIPC:  state <= S_UIMM;
                  OP_BRANCH:         state <= S_BRANCH;
                  OP_JAL:            state <= S_JAL;
                  OP_JALR:           state <= S_JALR;
                  default: begin
                     state   <= S_TRAP;
                     illegal <= 1'b1;
                  end
               endcase
            end
            S_MEMADR: state <= op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMWB, S_ALUWB: state <= S_FETCH;
            S_EXECR, S_EXECI, S_UIMM, S_JAL: state <= S_ALUWB;
            S_BRANCH: begin
               if (funct3 == 3'b010 || funct3 == 3'b011) begin
                  state   <= S_TRAP;
                  illegal <= 1'b1;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_JALR: state <= S_JAL;
            S_TRAP: state <= S_TRAP;
            default: state <= S_TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: expected per-cycle outputs come from an instruction-level
// model that expands each instruction into its state walk.
module tb_mc_ctrl;

   localparam int TO = 4;
   localparam int FE = 0, DE = 1, MA = 2, MR = 3, MWB = 4, MWR = 5, XR = 6;
   localparam int XI = 7, UI = 8, AW = 9, BR = 10, JR = 11, JL = 12, TR = 13;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [2:0] imm_src;
   logic [3:0] alu_control, state_o;
   logic       illegal, bus_err;

   always #5 clk = ~clk;

   mc_ctrl #(.ALU_CTRL_W(4), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal),
      .bus_err(bus_err), .state_o(state_o)
   );

   typedef struct {
      logic [3:0] st;
      logic       mreq, mwr, adr, irw, pcw, rw, ill, berr;
      logic [1:0] a, b, rs;
      logic [2:0] imm;
      logic [3:0] alu;
   } exp_t;

   exp_t q[$];
   exp_t ce;
   int   errs = 0, checks = 0, mw_cnt = 0, n;
   logic m_ill = 1'b0, m_berr = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [2:0] imm_of(input logic [6:0] o);
      if (o == 7'b0100011) return 3'd1;
      if (o == 7'b1100011) return 3'd2;
      if (o == 7'b1101111) return 3'd3;
      if (o == 7'b0110111 || o == 7'b0010111) return 3'd4;
      return 3'd0;
   endfunction

   function automatic logic [3:0] alu_ref(input logic rtype);
      case (funct3)
         3'd0: return (rtype && funct7b5) ? 4'd1 : 4'd0;
         3'd1: return 4'd7;
         3'd2: return 4'd5;
         3'd3: return 4'd6;
         3'd4: return 4'd4;
         3'd5: return funct7b5 ? 4'd9 : 4'd8;
         3'd6: return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   function automatic logic taken();
      if (funct3 == 3'd0) return zero;
      if (funct3 == 3'd1) return !zero;
      if (funct3 == 3'd4) return lt;
      if (funct3 == 3'd5) return !lt;
      if (funct3 == 3'd6) return ltu;
      if (funct3 == 3'd7) return !ltu;
      return 1'b0;
   endfunction

   // Outputs that must be visible while the machine sits in state st.
   function automatic exp_t model(input int st);
      exp_t e;
      e = '{default: '0};
      e.st = 4'(st); e.ill = m_ill; e.berr = m_berr; e.imm = imm_of(op);
      case (st)
         FE:  begin e.mreq = 1; e.b = 2; e.rs = 2; e.irw = mem_ready; e.pcw = mem_ready; end
         DE:  begin e.a = 1; e.b = 1; end
         MA:  begin e.a = 2; e.b = 1; end
         MR:  begin e.mreq = 1; e.adr = 1; end
         MWB: begin e.rs = 1; e.rw = 1; end
         MWR: begin e.mreq = 1; e.mwr = 1; e.adr = 1; end
         XR:  begin e.a = 2; e.alu = alu_ref(1'b1); end
         XI:  begin e.a = 2; e.b = 1; e.alu = alu_ref(1'b0); end
         UI:  begin e.b = 1; if (op == 7'b0110111) e.alu = 4'd10; else e.a = 1; end
         AW:  e.rw = 1;
         BR:  begin e.a = 2; e.alu = 4'd1; e.pcw = taken(); end
         JR:  begin e.a = 2; e.b = 1; end
         JL:  begin e.a = 1; e.b = 2; e.pcw = 1; end
         default: ;
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0) begin
         ce = q.pop_front();
         chk("state_o", state_o, ce.st);
         chk("mem_req", mem_req, ce.mreq);
         chk("mem_write", mem_write, ce.mwr);
         chk("adr_src", adr_src, ce.adr);
         chk("ir_write", ir_write, ce.irw);
         chk("pc_write", pc_write, ce.pcw);
         chk("reg_write", reg_write, ce.rw);
         chk("alu_src_a", alu_src_a, ce.a);
         chk("alu_src_b", alu_src_b, ce.b);
         chk("result_src", result_src, ce.rs);
         chk("imm_src", imm_src, ce.imm);
         chk("alu_control", alu_control, ce.alu);
         chk("illegal", illegal, ce.ill);
         chk("bus_err", bus_err, ce.berr);
      end
      if (mem_write === 1'b1) mw_cnt++;
   end

   task automatic step(input int st, input logic rdy);
      mem_ready = rdy;
      q.push_back(model(st));
      @(posedge clk);
      #1;
   endtask

   // Expand one instruction into its state walk (with memory wait cycles) and run it.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic f7,
                            input int fwait, input int mwait, input logic idle,
                            input int ntrap, output int ncyc);
      int   sq[$];
      logic rq[$];
      logic trap, ill;
      int   mst;
      op = o; funct3 = f; funct7b5 = f7;
      trap = 0; ill = 0;
      for (int i = 0; i < ((fwait >= TO) ? TO : fwait); i++) begin sq.push_back(FE); rq.push_back(1'b0); end
      if (fwait >= TO) trap = 1;
      else begin
         sq.push_back(FE); rq.push_back(1'b1);
         sq.push_back(DE); rq.push_back(idle);
         case (o)
            7'b0000011, 7'b0100011: begin
               mst = (o == 7'b0000011) ? MR : MWR;
               sq.push_back(MA); rq.push_back(idle);
               for (int i = 0; i < ((mwait >= TO) ? TO : mwait); i++) begin sq.push_back(mst); rq.push_back(1'b0); end
               if (mwait >= TO) trap = 1;
               else begin
                  sq.push_back(mst); rq.push_back(1'b1);
                  if (mst == MR) begin sq.push_back(MWB); rq.push_back(idle); end
               end
            end
            7'b0110011: begin sq.push_back(XR); rq.push_back(idle); sq.push_back(AW); rq.push_back(idle); end
            7'b0010011: begin sq.push_back(XI); rq.push_back(idle); sq.push_back(AW); rq.push_back(idle); end
            7'b0110111, 7'b0010111: begin sq.push_back(UI); rq.push_back(idle); sq.push_back(AW); rq.push_back(idle); end
            7'b1100011: begin
               sq.push_back(BR); rq.push_back(idle);
               if (f == 3'd2 || f == 3'd3) begin trap = 1; ill = 1; end
            end
            7'b1101111: begin sq.push_back(JL); rq.push_back(idle); sq.push_back(AW); rq.push_back(idle); end
            7'b1100111: begin
               sq.push_back(JR); rq.push_back(idle); sq.push_back(JL); rq.push_back(idle);
               sq.push_back(AW); rq.push_back(idle);
            end
            default: begin trap = 1; ill = 1; end
         endcase
      end
      ncyc = sq.size();
      for (int i = 0; i < sq.size(); i++) step(sq[i], rq[i]);
      if (trap) begin
         if (ill) m_ill = 1'b1; else m_berr = 1'b1;
         for (int i = 0; i < ntrap; i++) step(TR, idle);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_adr_src", adr_src, 0);
      chk("rst_ir_write", ir_write, 0);
      chk("rst_pc_write", pc_write, 0);
      chk("rst_reg_write", reg_write, 0);
      m_ill = 1'b0; m_berr = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_state", state_o, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_bus_err", bus_err, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      // Literal pins on the model itself.
      op = 7'b1100011; mem_ready = 1'b1;
      funct3 = 3'b001; zero = 1; ce = model(BR); chk("pin_bne_zero1", ce.pcw, 0);
      zero = 0;                  ce = model(BR); chk("pin_bne_zero0", ce.pcw, 1);
      funct3 = 3'b101; lt = 0;   ce = model(BR); chk("pin_bge_lt0", ce.pcw, 1);
      op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1; ce = model(XR); chk("pin_sub", ce.alu, 1);
      op = 7'b0010011;           ce = model(XI); chk("pin_addi", ce.alu, 0);
      op = 7'b0000011; ce = model(MWB); chk("pin_memwb_rs", ce.rs, 1);
      mem_ready = 1'b0; ce = model(FE); chk("pin_fetch_wait_irw", ce.irw, 0);

      #1;
      do_reset();
      run_instr(7'b0000011, 3'd2, 0, 0, 0, 1'b1, 0, n);
      chk("lw_cycles", n, 5);
      mw_cnt = 0;
      run_instr(7'b0100011, 3'd2, 0, 0, 3, 1'b1, 0, n);
      chk("sw_mem_write_cycles", mw_cnt, 4);
      run_instr(7'b0110011, 3'd0, 1, 2, 0, 1'b0, 0, n);
      run_instr(7'b0110011, 3'd5, 1, 0, 0, 1'b1, 0, n);
      run_instr(7'b0110011, 3'd7, 0, 1, 0, 1'b0, 0, n);
      run_instr(7'b0010011, 3'd2, 0, 0, 0, 1'b1, 0, n);
      run_instr(7'b0010011, 3'd5, 1, 0, 0, 1'b1, 0, n);
      run_instr(7'b0010011, 3'd0, 1, 0, 0, 1'b0, 0, n);
      run_instr(7'b0110111, 3'd0, 0, 0, 0, 1'b1, 0, n);
      run_instr(7'b0010111, 3'd0, 0, 0, 0, 1'b1, 0, n);
      zero = 1; run_instr(7'b1100011, 3'd1, 0, 0, 0, 1'b1, 0, n);
      zero = 0; run_instr(7'b1100011, 3'd1, 0, 0, 0, 1'b1, 0, n);
      lt = 0;   run_instr(7'b1100011, 3'd5, 0, 0, 0, 1'b1, 0, n);
      ltu = 1;  run_instr(7'b1100011, 3'd6, 0, 0, 0, 1'b0, 0, n);
      zero = 1; run_instr(7'b1100011, 3'd0, 0, 0, 0, 1'b1, 0, n);
      lt = 1;   run_instr(7'b1100011, 3'd4, 0, 0, 0, 1'b1, 0, n);
      run_instr(7'b1101111, 3'd0, 0, 0, 0, 1'b1, 0, n);
      run_instr(7'b1100111, 3'd0, 0, 0, 0, 1'b1, 0, n);

      run_instr(7'b0000000, 3'd0, 0, 0, 0, 1'b1, 10, n);
      chk("illegal_held", illegal, 1);
      do_reset();
      run_instr(7'b0000011, 3'd2, 0, 0, 1, 1'b1, 0, n);

      zero = 0;
      run_instr(7'b1100011, 3'd2, 0, 0, 0, 1'b1, 3, n);
      do_reset();
      run_instr(7'b0110011, 3'd0, 0, 4, 0, 1'b1, 3, n);
      chk("fetch_timeout_bus_err", bus_err, 1);
      do_reset();
      run_instr(7'b0000011, 3'd2, 0, 0, 6, 1'b1, 3, n);
      do_reset();

      op = 7'b0000011; funct3 = 3'd2; funct7b5 = 0;
      step(FE, 1'b1); step(DE, 1'b1); step(MA, 1'b1);
      mem_ready = 1'b0;
      #1;
      chk("memread_mem_req", mem_req, 1);
      chk("memread_state", state_o, MR);
      do_reset();
      run_instr(7'b0100011, 3'd2, 0, 0, 0, 1'b1, 0, n);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
